// File: rtl/ct_lsu_pfu_pe_arb_pkg.sv
// Shared definitions for the prefetch-engine request arbiter:
// default sizes, source-tag encodings and the round-robin pick helper.
package ct_lsu_pfu_pe_arb_pkg;

    localparam int PFU_ENTRY_NUM = 9;   // index 0 = global buffer, 1..8 = stride buffers
    localparam int PFU_SRC_W     = 2;

    typedef enum logic [1:0] {
        SRC_L1 = 2'b00,
        SRC_L2 = 2'b01
    } pfu_src_e;

    // Index of the first set bit of req, scanning upward from ptr+1 and
    // wrapping modulo n. Returns ptr when req is empty; callers qualify the
    // result with |req. Scanning from offset n down to offset 1 lets the
    // closest hit overwrite the farther ones.
    function automatic int unsigned rr_pick(input logic [31:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        rr_pick = ptr;
        for (int unsigned k = 0; k < 32; k++) begin
            if (k < n) begin
                idx = ptr + n - k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[4:0]]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/ct_lsu_pfu_pe_req_arb_if.sv
// Request/grant bundle between the PFU buffers, the arbiter and the
// downstream MMU/BIU request muxes. slave = arbiter side, master = environment.
interface ct_lsu_pfu_pe_req_arb_if
    import ct_lsu_pfu_pe_arb_pkg::*;
#(
    parameter int ENTRY_NUM = PFU_ENTRY_NUM,
    parameter int SRC_W     = PFU_SRC_W
);
    logic                       cp0_lsu_pfu_mmu_dis;
    logic                       pfu_pop_all_vld;
    logic [ENTRY_NUM-1:0]       pfu_entry_mmu_req;
    logic [ENTRY_NUM*SRC_W-1:0] pfu_entry_mmu_req_src;
    logic [ENTRY_NUM-1:0]       pfu_entry_biu_req;
    logic [ENTRY_NUM*SRC_W-1:0] pfu_entry_biu_req_src;
    logic                       pfu_mmu_pe_req;
    logic [ENTRY_NUM-1:0]       pfu_mmu_pe_req_id;
    logic [SRC_W-1:0]           pfu_mmu_pe_req_src;
    logic                       pfu_mmu_pe_req_grnt;
    logic [ENTRY_NUM-1:0]       pfu_entry_mmu_grnt;
    logic                       pfu_biu_pe_req;
    logic [ENTRY_NUM-1:0]       pfu_biu_pe_req_id;
    logic [SRC_W-1:0]           pfu_biu_pe_req_src;
    logic                       pfu_biu_pe_req_grnt;
    logic [ENTRY_NUM-1:0]       pfu_entry_biu_grnt;

    modport slave (
        input  cp0_lsu_pfu_mmu_dis, pfu_pop_all_vld,
        input  pfu_entry_mmu_req, pfu_entry_mmu_req_src,
        input  pfu_entry_biu_req, pfu_entry_biu_req_src,
        input  pfu_mmu_pe_req_grnt, pfu_biu_pe_req_grnt,
        output pfu_mmu_pe_req, pfu_mmu_pe_req_id, pfu_mmu_pe_req_src, pfu_entry_mmu_grnt,
        output pfu_biu_pe_req, pfu_biu_pe_req_id, pfu_biu_pe_req_src, pfu_entry_biu_grnt
    );

    modport master (
        output cp0_lsu_pfu_mmu_dis, pfu_pop_all_vld,
        output pfu_entry_mmu_req, pfu_entry_mmu_req_src,
        output pfu_entry_biu_req, pfu_entry_biu_req_src,
        output pfu_mmu_pe_req_grnt, pfu_biu_pe_req_grnt,
        input  pfu_mmu_pe_req, pfu_mmu_pe_req_id, pfu_mmu_pe_req_src, pfu_entry_mmu_grnt,
        input  pfu_biu_pe_req, pfu_biu_pe_req_id, pfu_biu_pe_req_src, pfu_entry_biu_grnt
    );

endinterface

// File: rtl/ct_lsu_pfu_pe_arb_chan.sv
// One arbitration channel: round-robin pointer, one-entry output slot and
// grant pulse generation. kill_i empties the slot, blocks loading and
// suppresses the grant pulse for the current cycle.
module ct_lsu_pfu_pe_arb_chan
    import ct_lsu_pfu_pe_arb_pkg::*;
#(
    parameter int ENTRY_NUM = PFU_ENTRY_NUM,
    parameter int SRC_W     = PFU_SRC_W
) (
    input  logic                       forever_cpuclk,
    input  logic                       cpurst_b,
    input  logic                       kill_i,
    input  logic [ENTRY_NUM-1:0]       req_i,
    input  logic [ENTRY_NUM*SRC_W-1:0] req_src_i,
    input  logic                       grnt_i,
    output logic                       pe_req_o,
    output logic [ENTRY_NUM-1:0]       pe_req_id_o,
    output logic [SRC_W-1:0]           pe_req_src_o,
    output logic [ENTRY_NUM-1:0]       entry_grnt_o
);

    localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    logic                 vld_q, vld_d;
    logic [ENTRY_NUM-1:0] id_q, id_d;
    logic [SRC_W-1:0]     src_q, src_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;

    logic [ENTRY_NUM-1:0] elig;
    logic [ENTRY_NUM-1:0] win_oh;
    logic [PTR_W-1:0]     win_idx;
    logic [SRC_W-1:0]     win_src;
    logic                 any_elig;
    logic                 fire;
    logic                 owner_drop;
    logic                 load;

    // Eligible set excludes the current owner; winner picked round-robin.
    always_comb begin
        elig       = kill_i ? '0 : (req_i & ~(vld_q ? id_q : '0));
        any_elig   = |elig;
        win_idx    = PTR_W'(rr_pick(32'(elig), 32'(ptr_q), ENTRY_NUM));
        fire       = vld_q & grnt_i & ~kill_i;
        owner_drop = vld_q & ~|(req_i & id_q);
        load       = (~vld_q | grnt_i) & ~kill_i & any_elig;
    end

    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_win_oh
        assign win_oh[gi] = any_elig && (win_idx == PTR_W'(gi));
    end

    // Source tag of the winning entry, sampled only at load.
    always_comb begin
        win_src = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (win_oh[i]) begin
                win_src = win_src | req_src_i[i*SRC_W +: SRC_W];
            end
        end
    end

    // Slot next state: reload has priority over any clear cause.
    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        src_d = src_q;
        ptr_d = ptr_q;
        if (load) begin
            vld_d = 1'b1;
            id_d  = win_oh;
            src_d = win_src;
            ptr_d = win_idx;
        end else if (kill_i | fire | owner_drop) begin
            vld_d = 1'b0;
            id_d  = '0;
            src_d = '0;
        end
    end

    // Slot and pointer registers; pointer resets so entry 0 wins first.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld_q <= 1'b0;
            id_q  <= '0;
            src_q <= '0;
            ptr_q <= PTR_W'(ENTRY_NUM - 1);
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
            src_q <= src_d;
            ptr_q <= ptr_d;
        end
    end

    assign pe_req_o     = vld_q;
    assign pe_req_id_o  = id_q;
    assign pe_req_src_o = src_q;
    assign entry_grnt_o = id_q & {ENTRY_NUM{fire}};

endmodule

// File: rtl/ct_lsu_pfu_pe_req_arb.sv
// Prefetch-engine request arbiter: MMU and BIU channels shared among the
// prefetch buffers. Adds MMU disable and pop-all gating around two channel
// instances. Optional stall counters enabled by macro PFU_PE_ARB_PERF_EN.
module ct_lsu_pfu_pe_req_arb
    import ct_lsu_pfu_pe_arb_pkg::*;
#(
    parameter int ENTRY_NUM = PFU_ENTRY_NUM,
    parameter int SRC_W     = PFU_SRC_W
) (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst_b,
    ct_lsu_pfu_pe_req_arb_if.slave        arb_if
`ifdef PFU_PE_ARB_PERF_EN
    ,
    output logic [15:0]                   pfu_arb_mmu_stall_cnt,
    output logic [15:0]                   pfu_arb_biu_stall_cnt
`endif
);

    logic mmu_kill;
    logic biu_kill;

    // MMU disable drains the MMU slot without a grant; pop-all drains both.
    always_comb begin
        mmu_kill = arb_if.pfu_pop_all_vld | arb_if.cp0_lsu_pfu_mmu_dis;
        biu_kill = arb_if.pfu_pop_all_vld;
    end

    ct_lsu_pfu_pe_arb_chan #(.ENTRY_NUM(ENTRY_NUM), .SRC_W(SRC_W)) u_mmu_chan (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .kill_i         (mmu_kill),
        .req_i          (arb_if.pfu_entry_mmu_req),
        .req_src_i      (arb_if.pfu_entry_mmu_req_src),
        .grnt_i         (arb_if.pfu_mmu_pe_req_grnt),
        .pe_req_o       (arb_if.pfu_mmu_pe_req),
        .pe_req_id_o    (arb_if.pfu_mmu_pe_req_id),
        .pe_req_src_o   (arb_if.pfu_mmu_pe_req_src),
        .entry_grnt_o   (arb_if.pfu_entry_mmu_grnt)
    );

    ct_lsu_pfu_pe_arb_chan #(.ENTRY_NUM(ENTRY_NUM), .SRC_W(SRC_W)) u_biu_chan (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .kill_i         (biu_kill),
        .req_i          (arb_if.pfu_entry_biu_req),
        .req_src_i      (arb_if.pfu_entry_biu_req_src),
        .grnt_i         (arb_if.pfu_biu_pe_req_grnt),
        .pe_req_o       (arb_if.pfu_biu_pe_req),
        .pe_req_id_o    (arb_if.pfu_biu_pe_req_id),
        .pe_req_src_o   (arb_if.pfu_biu_pe_req_src),
        .entry_grnt_o   (arb_if.pfu_entry_biu_grnt)
    );

`ifdef PFU_PE_ARB_PERF_EN
    logic [15:0] mmu_stall_cnt_q, mmu_stall_cnt_d;
    logic [15:0] biu_stall_cnt_q, biu_stall_cnt_d;

    // Count cycles a valid slot waits for its grant, saturating.
    always_comb begin
        mmu_stall_cnt_d = mmu_stall_cnt_q;
        biu_stall_cnt_d = biu_stall_cnt_q;
        if (arb_if.pfu_pop_all_vld) begin
            mmu_stall_cnt_d = '0;
            biu_stall_cnt_d = '0;
        end else begin
            if (arb_if.pfu_mmu_pe_req && !arb_if.pfu_mmu_pe_req_grnt &&
                mmu_stall_cnt_q != 16'hFFFF) begin
                mmu_stall_cnt_d = mmu_stall_cnt_q + 16'd1;
            end
            if (arb_if.pfu_biu_pe_req && !arb_if.pfu_biu_pe_req_grnt &&
                biu_stall_cnt_q != 16'hFFFF) begin
                biu_stall_cnt_d = biu_stall_cnt_q + 16'd1;
            end
        end
    end

    // Stall counter registers.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            mmu_stall_cnt_q <= '0;
            biu_stall_cnt_q <= '0;
        end else begin
            mmu_stall_cnt_q <= mmu_stall_cnt_d;
            biu_stall_cnt_q <= biu_stall_cnt_d;
        end
    end

    assign pfu_arb_mmu_stall_cnt = mmu_stall_cnt_q;
    assign pfu_arb_biu_stall_cnt = biu_stall_cnt_q;
`endif

endmodule
